bus_requester: RTL and testbench

Requester-side agent for one master port of the 4-way round-robin shared-bus arbiter. It queues single-beat write commands from its local master and raises `req` while work is pending. On every cycle the arbiter grants it, it drives one beat onto the shared bus. One instance sits on each `req[i]`/`grant[i]` pair. Its outputs are OR-muxed onto the bus by grant.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_requester_if.sv | 31 +++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/bus_requester.sv | 106 ++++++++++
 tb/tb_bus_requester.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the shared-bus requester: default widths,
// FSM state encoding and the queued beat layout.
package bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } req_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } beat_t;

endpackage

// File: rtl/bus_requester_if.sv
// Command handshake plus request/grant and shared-bus beat signals of one
// requester port; master is the requester side, slave the master/arbiter/bus side.
interface bus_requester_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              req;
    logic              grant;
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, grant, bus_ready,
        output cmd_ready, req, bus_valid, bus_addr, bus_wdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, grant, bus_ready,
        input  cmd_ready, req, bus_valid, bus_addr, bus_wdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; head is visible combinationally on dout_o.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/bus_requester.sv
// Requester agent for one arbiter port: queues write commands, requests the bus
// while work is pending and drives one beat per granted cycle from the queue head.
module bus_requester
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    bus_requester_if.master     bus,
    output logic [1:0]          state,
    output logic                starve,
    output logic [15:0]         beat_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = ADDR_W + DATA_W;

    logic [BW-1:0] head_s;
    logic          full_s, empty_s;
    logic [CW-1:0] count_s, count_next_s;
    logic          push_s, bus_valid_s, beat_done_s, req_s;

    req_state_e    state_q;
    logic [7:0]    wait_q, wait_d;
    logic          starve_q;
    logic [15:0]   beat_cnt_q;

    assign push_s       = bus.cmd_valid && !full_s && !rst;
    assign bus_valid_s  = bus.grant && !empty_s && !rst;
    assign beat_done_s  = bus_valid_s && bus.bus_ready;
    assign count_next_s = count_s + CW'(push_s) - CW'(beat_done_s);
    // Drop the request in the cycle the last queued beat completes
    assign req_s        = !rst && ((count_s > CW'(1)) ||
                                   ((count_s == CW'(1)) && !beat_done_s));

    assign bus.cmd_ready = !full_s && !rst;
    assign bus.req       = req_s;
    assign bus.bus_valid = bus_valid_s;
    assign bus.bus_addr  = bus_valid_s ? head_s[BW-1:DATA_W] : {ADDR_W{1'b0}};
    assign bus.bus_wdata = bus_valid_s ? head_s[DATA_W-1:0]  : {DATA_W{1'b0}};

    assign state    = state_q;
    assign starve   = starve_q;
    assign beat_cnt = beat_cnt_q;

    sync_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .din_i   ({bus.cmd_addr, bus.cmd_wdata}),
        .pop_i   (beat_done_s),
        .dout_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Requester FSM driven by next queue occupancy and beat completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (count_next_s == {CW{1'b0}}) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_q <= ST_WAIT;
                ST_WAIT:  state_q <= beat_done_s ? ST_BURST : ST_WAIT;
                ST_BURST: state_q <= (req_s && !beat_done_s) ? ST_WAIT : ST_BURST;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of cycles spent requesting without progress
    always_comb begin
        wait_d = wait_q;
        if (beat_done_s || !req_s) begin
            wait_d = 8'd0;
        end else if (wait_q != 8'hFF) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Wait counter, starvation flag and completed-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q     <= 8'd0;
            starve_q   <= 1'b0;
            beat_cnt_q <= 16'd0;
        end else begin
            wait_q     <= wait_d;
            starve_q   <= (wait_d >= 8'(TIMEOUT));
            beat_cnt_q <= beat_done_s ? (beat_cnt_q + 16'd1) : beat_cnt_q;
        end
    end

endmodule

// File: tb/tb_bus_requester.sv
// Randomised bench for bus_requester: a queue-based reference model predicts
// every output each cycle, plus directed checks at the interesting boundaries.
module tb_bus_requester;
    import bus_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  state;
    logic        starve;
    logic [15:0] beat_cnt;

    bus_requester_if #(.ADDR_W(16), .DATA_W(32)) bus_if ();

    bus_requester #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .state    (state),
        .starve   (starve),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    beat_t      q[$];
    int         exp_beats  = 0;
    int         waiting    = 0;
    logic [1:0] exp_state  = 2'd0;
    logic       exp_starve = 1'b0;
    bit         model_ok   = 1'b0;

    // stimulus knobs
    bit          rst_v     = 1'b1;
    bit          cv        = 1'b0;
    bit          rdy       = 1'b1;
    bit          arb_en    = 1'b0;
    bit          force_gnt = 1'b0;
    bit          spur_en   = 1'b0;
    bit          last_req  = 1'b0;
    int          gnt_pct   = 100;
    logic [15:0] ca        = 16'h0000;
    logic [31:0] cd        = 32'h0000_0000;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
    task automatic step();
        int    sz;
        bit    g, e_bv, e_done, e_req, e_crdy;
        beat_t hd;
        beat_t nb;
        @(negedge clk);
        if (arb_en) begin
            g = last_req && ($urandom_range(0, 99) < gnt_pct);
            if (!g && spur_en && ($urandom_range(0, 15) == 0)) g = 1'b1;
        end else begin
            g = force_gnt;
        end
        rst                = rst_v;
        bus_if.grant       = g;
        bus_if.cmd_valid   = cv;
        bus_if.cmd_addr    = ca;
        bus_if.cmd_wdata   = cd;
        bus_if.bus_ready   = rdy;
        #1;
        sz     = q.size();
        e_bv   = !rst_v && g && (sz > 0);
        e_done = e_bv && rdy;
        e_req  = !rst_v && ((sz > 1) || ((sz == 1) && !e_done));
        e_crdy = !rst_v && (sz < DEPTH);
        hd     = (sz > 0) ? q[0] : '0;
        check_eq("req",       bus_if.req,       e_req);
        check_eq("cmd_ready", bus_if.cmd_ready, e_crdy);
        check_eq("bus_valid", bus_if.bus_valid, e_bv);
        check_eq("bus_addr",  bus_if.bus_addr,  e_bv ? hd.addr  : 16'h0000);
        check_eq("bus_wdata", bus_if.bus_wdata, e_bv ? hd.wdata : 32'h0000_0000);
        if (model_ok) begin
            check_eq("state",    state,    exp_state);
            check_eq("starve",   starve,   exp_starve);
            check_eq("beat_cnt", beat_cnt, exp_beats[15:0]);
        end
        if (rst_v) begin
            q.delete();
            exp_beats  = 0;
            waiting    = 0;
            exp_state  = 2'd0;
            exp_starve = 1'b0;
            model_ok   = 1'b1;
        end else begin
            if (e_done) begin
                void'(q.pop_front());
                exp_beats++;
            end
            if (cv && e_crdy) begin
                nb.addr  = ca;
                nb.wdata = cd;
                q.push_back(nb);
            end
            waiting    = (e_req && !e_done) ? ((waiting < 255) ? waiting + 1 : 255) : 0;
            exp_starve = (waiting >= TIMEOUT);
            if (q.size() == 0)                  exp_state = 2'd0;
            else if (e_done && exp_state != 2'd0) exp_state = 2'd2;
            else                                exp_state = 2'd1;
        end
        last_req = bus_if.req;
    endtask

    initial begin
        int b0;
        bus_if.grant     = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = 16'h0000;
        bus_if.cmd_wdata = 32'h0000_0000;
        bus_if.bus_ready = 1'b1;

        // reset
        rst_v = 1'b1;
        repeat (2) step();
        rst_v = 1'b0;
        step();
        check_eq("rst_state",  state,    2'd0);
        check_eq("rst_beats",  beat_cnt, 16'h0000);
        check_eq("rst_starve", starve,   1'b0);

        // single command through an idle arbiter
        arb_en = 1'b1; gnt_pct = 100; rdy = 1'b1;
        cv = 1'b1; ca = 16'h0010; cd = 32'hA5A5_A5A5;
        step();
        check_eq("single_accept", bus_if.cmd_ready, 1'b1);
        cv = 1'b0;
        step();
        check_eq("single_req_t1",   bus_if.req, 1'b1);
        check_eq("single_state_t1", state,      2'd1);
        step();
        check_eq("single_beat_valid", bus_if.bus_valid, 1'b1);
        check_eq("single_beat_addr",  bus_if.bus_addr,  16'h0010);
        check_eq("single_beat_data",  bus_if.bus_wdata, 32'hA5A5_A5A5);
        check_eq("single_req_drop",   bus_if.req,       1'b0);
        step();
        check_eq("single_beat_cnt", beat_cnt, 16'h0001);
        check_eq("single_state_t3", state,    2'd0);

        // fill the queue with no grant, then release one beat
        arb_en = 1'b0; force_gnt = 1'b0; cv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ca = 16'(i + 16'h0100); cd = $urandom;
            step();
        end
        step();
        check_eq("full_ready_low", bus_if.cmd_ready, 1'b0);
        force_gnt = 1'b1;
        step();
        check_eq("full_pop_valid", bus_if.bus_valid, 1'b1);
        check_eq("full_pop_addr",  bus_if.bus_addr,  16'h0100);
        force_gnt = 1'b0;
        step();
        check_eq("full_ready_back", bus_if.cmd_ready, 1'b1);
        cv = 1'b0; arb_en = 1'b1;
        repeat (12) step();

        // refused beat stays at the head and is retried on a later grant
        arb_en = 1'b0; force_gnt = 1'b0;
        cv = 1'b1; ca = 16'h0BEE; cd = 32'h1234_5678;
        step();
        cv = 1'b0;
        step();
        b0 = exp_beats;
        force_gnt = 1'b1; rdy = 1'b0;
        step();
        check_eq("retry_first_addr", bus_if.bus_addr, 16'h0BEE);
        force_gnt = 1'b0; rdy = 1'b1;
        step();
        check_eq("retry_no_count", beat_cnt, 16'(b0));
        force_gnt = 1'b1;
        step();
        check_eq("retry_again_addr", bus_if.bus_addr,  16'h0BEE);
        check_eq("retry_again_data", bus_if.bus_wdata, 32'h1234_5678);
        force_gnt = 1'b0;
        step();
        check_eq("retry_counted", beat_cnt, 16'(b0 + 1));

        // starvation: request held, grant withheld
        cv = 1'b1; ca = 16'h0777; cd = 32'hDEAD_BEEF;
        step();
        cv = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            step();
            if (k == 63) check_eq("starve_before", starve, 1'b0);
            if (k == 65) check_eq("starve_after_64", starve, 1'b1);
        end
        force_gnt = 1'b1;
        step();
        force_gnt = 1'b0;
        step();
        check_eq("starve_cleared", starve, 1'b0);

        // randomised traffic
        arb_en = 1'b1; spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cv      = ($urandom_range(0, 1) == 1);
            ca      = 16'($urandom);
            cd      = $urandom;
            rdy     = ($urandom_range(0, 9) < 7);
            gnt_pct = (i < 1500) ? 60 : 95;
            step();
        end

        // drain, then reset with two queued commands and a grant active
        spur_en = 1'b0; cv = 1'b0; rdy = 1'b1; gnt_pct = 100;
        repeat (12) step();
        arb_en = 1'b0; force_gnt = 1'b0; cv = 1'b1;
        ca = 16'h0A00; cd = 32'h0000_0001; step();
        ca = 16'h0A01; cd = 32'h0000_0002; step();
        cv = 1'b0; force_gnt = 1'b1; rdy = 1'b0;
        step();
        check_eq("pre_rst_valid", bus_if.bus_valid, 1'b1);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        step();
        check_eq("post_rst_req",   bus_if.req,       1'b0);
        check_eq("post_rst_valid", bus_if.bus_valid, 1'b0);
        check_eq("post_rst_state", state,            2'd0);
        check_eq("post_rst_ready", bus_if.cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
